// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: round-robin arbiter and bus master for the shared 8088-style
// memory/IO peripheral bus. One granted requester at a time runs a fixed
// T1..T4 bus cycle (ALE, RD_N/WR_N strobes, 20-bit address, one-hot chip select).
// All bus outputs come straight from flops, so strobes are glitch-free and
// take their reset values as soon as RESET_N falls.
// Optional build macro: MEM_BUS_SEQ_STATS_EN adds the per-requester saturating
// completion counters on port stat_cnt.
module mem_bus_sequencer #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned NCS       = 4,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 req_we,
    input  logic [NREQ-1:0][19:0]           req_addr,
    input  logic [NREQ-1:0][DATA_BITS-1:0]  req_wdata,
    output logic [NREQ-1:0]                 gnt,
    output logic [NREQ-1:0]                 done,
    output logic [DATA_BITS-1:0]            rdata,
    output logic                            ALE,
    output logic                            RD_N,
    output logic                            WR_N,
    output logic [19:0]                     ADDR,
    output logic [NCS-1:0]                  CS,
    inout  wire  [DATA_BITS-1:0]            DATA
`ifdef MEM_BUS_SEQ_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]           stat_cnt
`endif
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T1   = 3'd1;
    localparam logic [2:0] T2   = 3'd2;
    localparam logic [2:0] T3   = 3'd3;
    localparam logic [2:0] T4   = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      win_q, win_d;
    logic [19:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q;

    logic                 ale_q;
    logic                 rd_n_q;
    logic                 wr_n_q;
    logic                 oe_q;
    logic [NCS-1:0]       cs_q;
    logic [NREQ-1:0]      gnt_q;
    logic [NREQ-1:0]      done_q;

    logic                 arb_found;
    logic [IdxW-1:0]      arb_idx;
    logic [IdxW-1:0]      cand;
    logic [NCS-1:0]       cs_dec;
    logic [NREQ-1:0]      win_oh_d;
    logic                 xfer_d;
    logic                 active_d;

    // Round-robin search starting at the pointer; first pending requester wins
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NREQ);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Bus cycle sequencing: arbitration happens only in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arb_found) state_d = T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch: inputs are sampled only on the IDLE->T1 edge
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        win_d   = win_q;
        if ((state_q == IDLE) && arb_found) begin
            addr_d  = req_addr[arb_idx];
            we_d    = req_we[arb_idx];
            wdata_d = req_wdata[arb_idx];
            win_d   = arb_idx;
        end
    end

    // Pointer moves past the winner as its cycle retires
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == T4) begin
            ptr_d = IdxW'((32'(win_q) + 1) % NREQ);
        end
    end

    // Chip-select region decode; regions at or beyond NCS select nothing
    always_comb begin
        cs_dec = '0;
        for (int unsigned k = 0; k < NCS; k++) begin
            if (32'(addr_d[19:18]) == k) begin
                cs_dec[k] = 1'b1;
            end
        end
    end

    // One-hot form of the (next) winner for gnt/done
    always_comb begin
        win_oh_d = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (32'(win_d) == k) begin
                win_oh_d[k] = 1'b1;
            end
        end
    end

    assign xfer_d   = (state_d == T2) || (state_d == T3);
    assign active_d = (state_d != IDLE);

    // State, latched request, pointer and captured read data
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            // Read data is taken on the edge that ends T3
            if ((state_q == T3) && !we_q) begin
                rdata_q <= DATA;
            end
        end
    end

    // Registered bus strobes and handshakes, decoded from the next state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ale_q  <= 1'b0;
            rd_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            oe_q   <= 1'b0;
            cs_q   <= '0;
            gnt_q  <= '0;
            done_q <= '0;
        end else begin
            ale_q  <= (state_d == T1);
            rd_n_q <= !(xfer_d && !we_d);
            wr_n_q <= !(xfer_d && we_d);
            oe_q   <= xfer_d && we_d;
            cs_q   <= active_d ? cs_dec : '0;
            gnt_q  <= active_d ? win_oh_d : '0;
            done_q <= (state_d == T4) ? win_oh_d : '0;
        end
    end

    assign ALE   = ale_q;
    assign RD_N  = rd_n_q;
    assign WR_N  = wr_n_q;
    assign ADDR  = addr_q;
    assign CS    = cs_q;
    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign DATA  = oe_q ? wdata_q : {DATA_BITS{1'bz}};

`ifdef MEM_BUS_SEQ_STATS_EN
    logic [NREQ-1:0][15:0] stat_q;

    // Completion counters, one per requester, sticking at all-ones
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (done_q[k] && (stat_q[k] != 16'hFFFF)) begin
                    stat_q[k] <= stat_q[k] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt = stat_q;
`endif

    // Strobes never overlap each other or the address latch pulse
    a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET_N) !(!RD_N && !WR_N));
    a_ale_excl:    assert property (@(posedge CLK) disable iff (!RESET_N)
                                    !(ALE && (!RD_N || !WR_N)));

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: directed scenarios followed by random requester
// traffic, checked every cycle against a transaction-level reference model and
// a behavioural peripheral memory on the bus.
module tb_mem_bus_sequencer;

    localparam int NREQ = 2;
    localparam int NCS  = 4;
    localparam int DB   = 8;

    logic                    CLK;
    logic                    RESET_N;
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_we;
    logic [NREQ-1:0][19:0]   req_addr;
    logic [NREQ-1:0][DB-1:0] req_wdata;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [DB-1:0]           rdata;
    logic                    ALE;
    logic                    RD_N;
    logic                    WR_N;
    logic [19:0]             ADDR;
    logic [NCS-1:0]          CS;
    wire  [DB-1:0]           bus_data;
`ifdef MEM_BUS_SEQ_STATS_EN
    logic [NREQ-1:0][15:0]   stat_cnt;
`endif

    mem_bus_sequencer #(
        .NREQ      (NREQ),
        .NCS       (NCS),
        .DATA_BITS (DB)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .ALE       (ALE),
        .RD_N      (RD_N),
        .WR_N      (WR_N),
        .ADDR      (ADDR),
        .CS        (CS),
        .DATA      (bus_data)
`ifdef MEM_BUS_SEQ_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Peripheral memory image is indexed by region and low address byte
    function automatic int unsigned midx(input logic [19:0] a);
        return {22'd0, a[19:18], a[7:0]};
    endfunction

    function automatic logic [7:0] init_val(input int unsigned i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Behavioural peripheral: drives data while RD_N is low, writes at end of a 2-cycle WR_N
    logic [7:0] mem [0:1023];
    logic       wr_low_q;
    assign bus_data = (!RD_N) ? mem[midx(ADDR)] : 8'bz;
    always @(posedge CLK) begin
        if (!WR_N && wr_low_q) mem[midx(ADDR)] <= bus_data;
        wr_low_q <= !WR_N;
    end

    // Reference model: m_t counts cycles into the current transaction (0 = no transaction)
    logic [7:0]  ref_mem [0:1023];
    int          m_t, m_ptr, m_win;
    logic [19:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wd, m_rd;
    int          m_cnt [NREQ];
    logic [NREQ-1:0] glog [$];

    task automatic model_reset();
        m_t   = 0;
        m_ptr = 0;
        m_win = 0;
        for (int k = 0; k < NREQ; k++) m_cnt[k] = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_ale"},   32'(ALE),   32'd0);
        check({pfx, "_rd_n"},  32'(RD_N),  32'd1);
        check({pfx, "_wr_n"},  32'(WR_N),  32'd1);
        check({pfx, "_cs"},    32'(CS),    32'd0);
        check({pfx, "_addr"},  32'(ADDR),  32'd0);
        check({pfx, "_gnt"},   32'(gnt),   32'd0);
        check({pfx, "_done"},  32'(done),  32'd0);
        check({pfx, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] eg, ed;
        logic [NCS-1:0]  ecs;
        bool_strobe: begin end
        eg  = '0;
        ed  = '0;
        ecs = '0;
        if (m_t != 0) eg[m_win] = 1'b1;
        if (m_t == 4) ed[m_win] = 1'b1;
        if ((m_t != 0) && (int'(m_addr[19:18]) < NCS)) ecs[m_addr[19:18]] = 1'b1;
        check("ale",  32'(ALE),  32'(m_t == 1));
        check("rd_n", 32'(RD_N), 32'(!((m_t == 2 || m_t == 3) && !m_we)));
        check("wr_n", 32'(WR_N), 32'(!((m_t == 2 || m_t == 3) && m_we)));
        check("gnt",  32'(gnt),  32'(eg));
        check("done", 32'(done), 32'(ed));
        check("cs",   32'(CS),   32'(ecs));
        if (m_t != 0) check("addr", 32'(ADDR), 32'(m_addr));
        if (m_we && (m_t == 2 || m_t == 3)) check("wdata_bus", 32'(bus_data), 32'(m_wd));
        if ((m_t == 4) && !m_we) check("rdata", 32'(rdata), 32'(m_rd));
    endtask

    // Advance one clock: update the model from inputs held across the edge, then compare
    task automatic tick(input bit drop_on_done);
        logic [NREQ-1:0]         r, rw;
        logic [NREQ-1:0][19:0]   ra;
        logic [NREQ-1:0][DB-1:0] rwd;
        bit found;
        r   = req;
        rw  = req_we;
        ra  = req_addr;
        rwd = req_wdata;
        @(posedge CLK);
        case (m_t)
            0: begin
                found = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    int c;
                    c = (m_ptr + i) % NREQ;
                    if (!found && r[c]) begin
                        found = 1'b1;
                        m_win = c;
                    end
                end
                if (found) begin
                    m_addr = ra[m_win];
                    m_we   = rw[m_win];
                    m_wd   = rwd[m_win];
                    m_t    = 1;
                end
            end
            3: begin
                if (m_we) ref_mem[midx(m_addr)] = m_wd;
                else      m_rd = ref_mem[midx(m_addr)];
                m_cnt[m_win]++;
                m_t = 4;
            end
            4: begin
                m_ptr = (m_win + 1) % NREQ;
                m_t   = 0;
            end
            default: m_t++;
        endcase
        #1;
        check_cycle();
        if (m_t == 1) glog.push_back(gnt);
        if (drop_on_done && (m_t == 4)) req[m_win] = 1'b0;
    endtask

    task automatic new_req(input int k);
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = 20'($urandom);
        req_wdata[k] = 8'($urandom);
        req[k]       = 1'b1;
    endtask

    // Random requester behaviour: hold until done, occasionally abandon or drop after grant
    task automatic drive_random();
        for (int k = 0; k < NREQ; k++) begin
            bit infl, fin;
            infl = (m_t != 0) && (m_win == k);
            fin  = (m_t == 4) && (m_win == k);
            if (fin) req[k] = 1'b0;
            if (infl && !fin) begin
                if (req[k] && ($urandom_range(0, 15) == 0)) req[k] = 1'b0;
            end else if (req[k]) begin
                if ($urandom_range(0, 15) == 0) req[k] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                new_req(k);
            end
        end
    endtask

    initial begin
        int dn, gcnt;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = init_val(i);
            ref_mem[i] = init_val(i);
        end
        wr_low_q  = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("por");
        @(negedge CLK);
        RESET_N = 1'b1;

        // Single read by requester 0
        req_addr[0] = 20'h00010;
        req_we[0]   = 1'b0;
        req[0]      = 1'b1;
        tick(1);
        check("rd_t1_ale", 32'(ALE), 32'd1);
        check("rd_t1_cs", 32'(CS), 32'b0001);
        tick(1);
        check("rd_t2_rd_n", 32'(RD_N), 32'd0);
        tick(1);
        tick(1);
        check("rd_done_cycle5", 32'(done), 32'b01);
        check("rd_value", 32'(rdata), 32'(init_val(midx(20'h00010))));
        tick(1);

        // Write by requester 1, then read it back
        req_addr[1]  = 20'h40005;
        req_we[1]    = 1'b1;
        req_wdata[1] = 8'hA5;
        req[1]       = 1'b1;
        tick(1);
        check("wr_t1_cs", 32'(CS), 32'b0010);
        tick(1);
        check("wr_t2_wr_n", 32'(WR_N), 32'd0);
        check("wr_t2_data", 32'(bus_data), 32'hA5);
        repeat (3) tick(1);
        req_we[1] = 1'b0;
        req[1]    = 1'b1;
        repeat (4) tick(1);
        check("wr_readback", 32'(rdata), 32'hA5);
        tick(1);

        // Both requesters held: grants alternate starting from requester 0
        glog.delete();
        req_addr[0] = 20'h80044;
        req_we[0]   = 1'b0;
        req_addr[1] = 20'hC0077;
        req_we[1]   = 1'b0;
        req         = 2'b11;
        repeat (20) tick(0);
        req = '0;
        check("rr_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            check("rr_order", 32'(glog[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
        end
        tick(0);

        // Move the pointer to 1, then reset in T2 of a write
        req_addr[0] = 20'h00020;
        req_we[0]   = 1'b0;
        req[0]      = 1'b1;
        repeat (5) tick(1);
        req_addr[1]  = 20'h80003;
        req_we[1]    = 1'b1;
        req_wdata[1] = 8'h5A;
        req[1]       = 1'b1;
        tick(1);
        tick(1);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        req = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        req_we = '0;
        req    = 2'b11;
        tick(1);
        check("rst_ptr_gnt", 32'(gnt), 32'b01);
        repeat (9) tick(1);

        // Drop after grant still completes
        req_addr[0] = 20'h00030;
        req_we[0]   = 1'b0;
        req[0]      = 1'b1;
        tick(0);
        req[0] = 1'b0;
        dn = 0;
        repeat (4) begin
            tick(0);
            if (done[0]) dn++;
        end
        check("drop_after_gnt_done", 32'(dn), 32'd1);

        // Request raised and dropped between edges is never granted
        req[1] = 1'b1;
        #2;
        req[1] = 1'b0;
        gcnt = 0;
        repeat (6) begin
            tick(0);
            if (gnt != '0) gcnt++;
        end
        check("glitch_no_gnt", 32'(gcnt), 32'd0);

        // Random traffic
        repeat (800) begin
            drive_random();
            tick(0);
        end
        req = '0;
        repeat (8) tick(0);

`ifdef MEM_BUS_SEQ_STATS_EN
        for (int k = 0; k < NREQ; k++) begin
            check("stat_cnt", 32'(stat_cnt[k]), 32'(m_cnt[k] > 65535 ? 65535 : m_cnt[k]));
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
